// File: rtl/snn_pkg.sv
// ---------------------------------------------------------------------------
// snn_pkg
//  Shared types and constants for the SNN spike front end.
//   enc_state_t  : encoder frame FSM states
//   SNN_DATA_W   : default intensity width
//   LFSR_TAPS    : tap mask for the 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1)
//   lfsr_step()  : one shift of that LFSR
//   chan_seed()  : per-channel seed derivation, never returns zero
//  Optional feature macro: SPIKE_ENC_LFSR_EN (the LFSR helpers are only
//  referenced when it is defined).
// ---------------------------------------------------------------------------
package snn_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } enc_state_t;

    localparam int SNN_DATA_W = 8;

    // Bits 15,13,12,10 of the state register (polynomial taps 16,14,13,11).
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Shift left, feedback = XOR of tapped bits into bit 0.
    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

    // Channel i uses base ^ (i+1); an all-zero LFSR would lock up, so
    // substitute 1 if the XOR happens to cancel out.
    function automatic logic [15:0] chan_seed(input logic [15:0] base, input int idx);
        logic [15:0] s;
        s = base ^ 16'(idx + 1);
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/spike_enc_channel.sv
// ---------------------------------------------------------------------------
// spike_enc_channel
//  One encoder channel. Latches the frame intensity on load and produces the
//  spike bit for the current time step; the parent registers it.
//  Optional feature macro: SPIKE_ENC_LFSR_EN
//   undefined : deterministic accumulator, spike = carry out of acc + x
//   defined   : stochastic mode, spike = (lfsr[DATA_W-1:0] < x)
// Ports
//  clk      in   1       system clock
//  reset    in   1       synchronous, active-high
//  load     in   1       latch x_in and restart the frame
//  step_en  in   1       a time step is being emitted this edge
//  x_in     in   DATA_W  intensity for this channel
//  spike    out  1       spike for the step being emitted (combinational)
// ---------------------------------------------------------------------------
module spike_enc_channel
    import snn_pkg::*;
#(
    parameter int DATA_W = SNN_DATA_W
`ifdef SPIKE_ENC_LFSR_EN
   ,parameter logic [15:0] SEED = 16'h0001
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              step_en,
    input  logic [DATA_W-1:0] x_in,
    output logic              spike
);

    logic [DATA_W-1:0] x_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            x_reg <= '0;
        end else if (load) begin
            x_reg <= x_in;
        end
    end

`ifdef SPIKE_ENC_LFSR_EN
    // Seeded only at reset so successive frames see fresh random values.
    logic [15:0] lfsr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= SEED;
        end else if (step_en) begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    assign spike = (lfsr_reg[DATA_W-1:0] < x_reg);
`else
    // Phase accumulator: the carry out of acc + x fires on average
    // x / 2^DATA_W times per step, giving floor(WINDOW*x / 2^DATA_W) per frame.
    logic [DATA_W-1:0] acc_reg;
    logic [DATA_W:0]   sum;

    assign sum   = {1'b0, acc_reg} + {1'b0, x_reg};
    assign spike = sum[DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_reg <= '0;
        end else if (load) begin
            acc_reg <= '0;
        end else if (step_en) begin
            acc_reg <= sum[DATA_W-1:0];
        end
    end
`endif

endmodule

// File: rtl/spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// spike_rate_encoder
//  Converts one frame of NUM_INPUTS unsigned intensities into WINDOW time
//  steps of spikes. Frames are accepted with a valid/ready handshake while
//  idle; each step is emitted on a registered spike vector.
//  Optional feature macro: SPIKE_ENC_LFSR_EN (stochastic LFSR encoding;
//  default build uses deterministic accumulators).
// Ports
//  clk          in   1                    system clock
//  reset        in   1                    synchronous, active-high
//  in_valid     in   1                    frame offered
//  in_ready     out  1                    encoder idle, frame can be accepted
//  in_data      in   NUM_INPUTS*DATA_W    channel i at [i*DATA_W +: DATA_W]
//  spikes       out  NUM_INPUTS           registered spikes for current step
//  spike_valid  out  1                    spikes holds a valid time step
//  frame_last   out  1                    current step is the last of frame
//  busy         out  1                    frame in progress
// ---------------------------------------------------------------------------
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int          NUM_INPUTS = 4,
    parameter int          DATA_W     = SNN_DATA_W,
    parameter int          WINDOW     = 16,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUM_INPUTS*DATA_W-1:0] in_data,
    output logic [NUM_INPUTS-1:0]        spikes,
    output logic                         spike_valid,
    output logic                         frame_last,
    output logic                         busy
);

    localparam int STEP_W = $clog2(WINDOW);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(WINDOW - 1);

    enc_state_t            state_reg, state_next;
    logic [STEP_W-1:0]     step_reg, step_next;
    logic [NUM_INPUTS-1:0] spikes_reg, spikes_next;
    logic                  spike_valid_reg, spike_valid_next;
    logic                  frame_last_reg, frame_last_next;

    logic                  load;
    logic                  step_en;
    logic [NUM_INPUTS-1:0] ch_spike;

    // ------------------------------------------------------------------
    // Channels
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_chan
`ifdef SPIKE_ENC_LFSR_EN
        localparam logic [15:0] CH_SEED = chan_seed(LFSR_SEED, gi);
        spike_enc_channel #(
            .DATA_W (DATA_W),
            .SEED   (CH_SEED)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .step_en (step_en),
            .x_in    (in_data[gi*DATA_W +: DATA_W]),
            .spike   (ch_spike[gi])
        );
`else
        spike_enc_channel #(
            .DATA_W (DATA_W)
        ) u_chan (
            .clk     (clk),
            .reset   (reset),
            .load    (load),
            .step_en (step_en),
            .x_in    (in_data[gi*DATA_W +: DATA_W]),
            .spike   (ch_spike[gi])
        );
`endif
    end

    // ------------------------------------------------------------------
    // Frame FSM and output staging
    // ------------------------------------------------------------------
    always_comb begin
        state_next       = state_reg;
        step_next        = step_reg;
        spikes_next      = '0;
        spike_valid_next = 1'b0;
        frame_last_next  = 1'b0;
        load             = 1'b0;
        step_en          = 1'b0;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    load       = 1'b1;
                    step_next  = '0;
                    state_next = RUN;
                end
            end
            RUN: begin
                step_en          = 1'b1;
                spikes_next      = ch_spike;
                spike_valid_next = 1'b1;
                frame_last_next  = (step_reg == LAST_STEP);
                if (step_reg == LAST_STEP) begin
                    // Return to IDLE on the final step so a new frame can
                    // be accepted on the very next edge (one-cycle gap).
                    step_next  = '0;
                    state_next = IDLE;
                end else begin
                    step_next = step_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= IDLE;
            step_reg        <= '0;
            spikes_reg      <= '0;
            spike_valid_reg <= 1'b0;
            frame_last_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            step_reg        <= step_next;
            spikes_reg      <= spikes_next;
            spike_valid_reg <= spike_valid_next;
            frame_last_reg  <= frame_last_next;
        end
    end

    assign in_ready    = (state_reg == IDLE);
    assign busy        = (state_reg == RUN);
    assign spikes      = spikes_reg;
    assign spike_valid = spike_valid_reg;
    assign frame_last  = frame_last_reg;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// ---------------------------------------------------------------------------
// tb_spike_rate_encoder
//  Directed, table-driven bench for spike_rate_encoder (NUM_INPUTS=4,
//  DATA_W=8, WINDOW=16). Expected spike patterns are hand-computed per
//  channel as 16-bit masks (bit k = spike at step k).
// ---------------------------------------------------------------------------
module tb_spike_rate_encoder;

    localparam int NI = 4;
    localparam int DW = 8;
    localparam int WIN = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NI*DW-1:0]  in_data = '0;
    logic [NI-1:0]     spikes;
    logic              spike_valid;
    logic              frame_last;
    logic              busy;

    int checks = 0;
    int errors = 0;

    spike_rate_encoder #(
        .NUM_INPUTS (NI),
        .DATA_W     (DW),
        .WINDOW     (WIN),
        .LFSR_SEED  (16'hACE1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .spikes      (spikes),
        .spike_valid (spike_valid),
        .frame_last  (frame_last),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NI*DW-1:0]     data;
        logic [NI-1:0][15:0]  pat;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer a frame (called at a sample point, #1 after an edge), check the
    // one-cycle handshake latency and WINDOW valid steps, and collect the
    // spike pattern. With hold set, in_valid stays high with next_data so the
    // following frame is offered back-to-back.
    task automatic send_frame(input string tag, input logic [NI*DW-1:0] data,
                              input bit hold, input logic [NI*DW-1:0] next_data,
                              output logic [NI-1:0][15:0] pat);
        int wait_cnt;
        int bad_valid;
        int bad_last;
        int bad_ready;
        wait_cnt  = 0;
        bad_valid = 0;
        bad_last  = 0;
        bad_ready = 0;
        pat       = '0;
        in_valid  = 1'b1;
        in_data   = data;
        while (!in_ready && wait_cnt < 100) begin
            tick();
            wait_cnt++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL %s ready_timeout: in_ready stayed 0 for %0d cycles", tag, wait_cnt);
        end
        tick();  // handshake edge
        check({tag, " gap_valid"}, 32'(spike_valid), 32'd0);
        check({tag, " busy"}, 32'(busy), 32'd1);
        if (hold) begin
            in_valid = 1'b1;
            in_data  = next_data;
        end else begin
            in_valid = 1'b0;
        end
        for (int i = 0; i < WIN; i++) begin
            tick();
            if (spike_valid !== 1'b1) bad_valid++;
            if (frame_last !== (i == WIN - 1)) bad_last++;
            if (in_ready !== (i == WIN - 1)) bad_ready++;
            for (int c = 0; c < NI; c++) pat[c][i] = spikes[c];
        end
        check({tag, " valid_steps_bad"}, 32'(bad_valid), 32'd0);
        check({tag, " frame_last_bad"}, 32'(bad_last), 32'd0);
        check({tag, " in_ready_bad"}, 32'(bad_ready), 32'd0);
        if (!hold) in_valid = 1'b0;
    endtask

    logic [NI-1:0][15:0] pat;
    logic [NI-1:0][15:0] exp_all_ffe;
    int idle_bad;

    initial begin
        vecs[0].data = {8'd255, 8'd128, 8'd64, 8'd0};
        vecs[0].pat  = {16'hFFFE, 16'hAAAA, 16'h8888, 16'h0000};
        vecs[1].data = {8'd192, 8'd32, 8'd16, 8'd1};
        vecs[1].pat  = {16'hEEEE, 16'h8080, 16'h8000, 16'h0000};
        vecs[2].data = {8'd64, 8'd0, 8'd255, 8'd96};
        vecs[2].pat  = {16'h8888, 16'h0000, 16'hFFFE, 16'hA4A4};
        vecs[3].data = {8'd128, 8'd128, 8'd128, 8'd128};
        vecs[3].pat  = {16'hAAAA, 16'hAAAA, 16'hAAAA, 16'hAAAA};
        exp_all_ffe  = {16'hFFFE, 16'hFFFE, 16'hFFFE, 16'hFFFE};

        // Power-on reset
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst spikes", 32'(spikes), 32'd0);
        check("rst spike_valid", 32'(spike_valid), 32'd0);
        check("rst frame_last", 32'(frame_last), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd1);

`ifndef SPIKE_ENC_LFSR_EN
        // Table-driven frames
        for (int v = 0; v < 4; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].data, 1'b0, '0, pat);
            for (int c = 0; c < NI; c++)
                check($sformatf("vec%0d ch%0d pattern", v, c), 32'(pat[c]), 32'(vecs[v].pat[c]));
            $display("vec%0d data=%08h spikes ch0..3 = %04h %04h %04h %04h",
                     v, vecs[v].data, pat[0], pat[1], pat[2], pat[3]);
            tick();
            check($sformatf("vec%0d valid_drop", v), 32'(spike_valid), 32'd0);
            check($sformatf("vec%0d last_drop", v), 32'(frame_last), 32'd0);
        end

        // Spike counts for {0,64,128,255}
        send_frame("cnt", vecs[0].data, 1'b0, '0, pat);
        check("cnt ch0", 32'($countones(pat[0])), 32'd0);
        check("cnt ch1", 32'($countones(pat[1])), 32'd4);
        check("cnt ch2", 32'($countones(pat[2])), 32'd8);
        check("cnt ch3", 32'($countones(pat[3])), 32'd15);
        repeat (2) tick();

        // in_valid held with different data during RUN: first frame unaffected,
        // held frame accepted as soon as in_ready rises.
        send_frame("hold_a", vecs[0].data, 1'b1, {4{8'd255}}, pat);
        for (int c = 0; c < NI; c++)
            check($sformatf("hold_a ch%0d pattern", c), 32'(pat[c]), 32'(vecs[0].pat[c]));
        $display("hold_a spikes ch0..3 = %04h %04h %04h %04h", pat[0], pat[1], pat[2], pat[3]);
        send_frame("hold_b", {4{8'd255}}, 1'b0, '0, pat);
        for (int c = 0; c < NI; c++)
            check($sformatf("hold_b ch%0d pattern", c), 32'(pat[c]), 32'(exp_all_ffe[c]));
        $display("hold_b spikes ch0..3 = %04h %04h %04h %04h", pat[0], pat[1], pat[2], pat[3]);
        repeat (2) tick();

        // Back-to-back frames of all 128: one idle cycle, 8 spikes each
        for (int f = 0; f < 3; f++) begin
            send_frame($sformatf("b2b%0d", f), vecs[3].data, 1'b0, '0, pat);
            for (int c = 0; c < NI; c++)
                check($sformatf("b2b%0d ch%0d count", f, c), 32'($countones(pat[c])), 32'd8);
            $display("b2b%0d spikes ch0..3 = %04h %04h %04h %04h", f, pat[0], pat[1], pat[2], pat[3]);
        end
        tick();
`endif

        // Reset held 3 cycles in the middle of a frame
        in_valid = 1'b1;
        in_data  = vecs[0].data;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        check("midrst pre valid", 32'(spike_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("midrst spikes", 32'(spikes), 32'd0);
        check("midrst spike_valid", 32'(spike_valid), 32'd0);
        check("midrst frame_last", 32'(frame_last), 32'd0);
        check("midrst busy", 32'(busy), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        tick();
        check("midrst in_ready", 32'(in_ready), 32'd1);
        idle_bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (spike_valid !== 1'b0 || frame_last !== 1'b0 || busy !== 1'b0) idle_bad++;
            tick();
        end
        check("midrst no_resume", 32'(idle_bad), 32'd0);
        $display("midrst done, idle violations=%0d", idle_bad);

`ifndef SPIKE_ENC_LFSR_EN
        // Clean frame after reset: accumulators must have been cleared
        send_frame("postrst", vecs[0].data, 1'b0, '0, pat);
        for (int c = 0; c < NI; c++)
            check($sformatf("postrst ch%0d pattern", c), 32'(pat[c]), 32'(vecs[0].pat[c]));
        $display("postrst spikes ch0..3 = %04h %04h %04h %04h", pat[0], pat[1], pat[2], pat[3]);
        tick();
`else
        begin
            int tot[NI];
            for (int c = 0; c < NI; c++) tot[c] = 0;
            for (int f = 0; f < 64; f++) begin
                send_frame($sformatf("lfsr%0d", f), {8'd128, 8'd0, 8'd128, 8'd0}, 1'b0, '0, pat);
                for (int c = 0; c < NI; c++) tot[c] += $countones(pat[c]);
                $display("lfsr frame %0d spikes ch0..3 = %04h %04h %04h %04h", f, pat[0], pat[1], pat[2], pat[3]);
            end
            check("lfsr ch0 zero", 32'(tot[0]), 32'd0);
            check("lfsr ch2 zero", 32'(tot[2]), 32'd0);
            checks++;
            if (tot[1] < 450 || tot[1] > 574) begin
                errors++;
                $display("FAIL lfsr ch1 total: got %0d, expected 450..574", tot[1]);
            end
            checks++;
            if (tot[3] < 450 || tot[3] > 574) begin
                errors++;
                $display("FAIL lfsr ch3 total: got %0d, expected 450..574", tot[3]);
            end
        end
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
